load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 4 +
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit and its interface.
package lsu_pkg;
   localparam int ADDR_WIDTH = 16;
endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus memory address/strobes for load_store_unit.
interface load_store_unit_if #(
   parameter int MEM_AW = lsu_pkg::ADDR_WIDTH
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [1:0]        req_size_i;
   logic              req_unsigned_i;
   logic [31:0]       req_addr_i;
   logic [31:0]       req_wdata_i;
   logic              resp_valid_o;
   logic [31:0]       resp_rdata_o;
   logic              resp_err_o;
   logic [MEM_AW-1:0] mem_addr_o;
   logic              mem_re_o;
   logic              mem_we_o;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, mem_addr_o, mem_re_o, mem_we_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, mem_addr_o, mem_re_o, mem_we_o
   );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit over a shared tri-state bus; load/word store 2 cycles, sub-word RMW store 3, error 1.
// Ready only in IDLE (no queuing). Define LSU_SUBWORD_EN for byte/half access, RMW stores and alignment errors.
module load_store_unit #(
   parameter int MEM_AW = lsu_pkg::ADDR_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.slave  bus,
   inout  tri   [31:0]       mem_bus_io
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]        r_state;
   logic              r_we;
   logic [MEM_AW-1:0] r_addr;
   logic [31:0]       r_wword;
   logic [31:0]       r_rdata;

   logic              w_accept;
   logic [1:0]        w_next_acc;
   logic [31:0]       w_load;
   logic [31:0]       w_merge;

   assign w_accept = bus.req_valid_i && (r_state == IDLE);

`ifdef LSU_SUBWORD_EN
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_err;
   logic        w_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_unused_addr;

   assign w_unused_addr = ^bus.req_addr_i;

   always_comb begin
      w_err = (bus.req_size_i == 2'b11) ||
              ((bus.req_size_i == 2'b01) && bus.req_addr_i[0]) ||
              ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
      if (w_err)
         w_next_acc = RESP;
      else if (bus.req_we_i && (bus.req_size_i == 2'b10))
         w_next_acc = WRITE;
      else
         w_next_acc = READ;
   end

   // Lane select and merge both work on the word the memory is driving during READ.
   always_comb begin
      case (r_addr[1:0])
         2'd0:    w_byte = mem_bus_io[7:0];
         2'd1:    w_byte = mem_bus_io[15:8];
         2'd2:    w_byte = mem_bus_io[23:16];
         default: w_byte = mem_bus_io[31:24];
      endcase
      w_half = r_addr[1] ? mem_bus_io[31:16] : mem_bus_io[15:0];
      case (r_size)
         2'b00:   w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = mem_bus_io;
      endcase
   end

   always_comb begin
      w_merge = mem_bus_io;
      if (r_size == 2'b00) begin
         case (r_addr[1:0])
            2'd0:    w_merge[7:0]   = r_wword[7:0];
            2'd1:    w_merge[15:8]  = r_wword[7:0];
            2'd2:    w_merge[23:16] = r_wword[7:0];
            default: w_merge[31:24] = r_wword[7:0];
         endcase
      end else if (r_addr[1]) begin
         w_merge[31:16] = r_wword[15:0];
      end else begin
         w_merge[15:0] = r_wword[15:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_accept) begin
         r_size     <= bus.req_size_i;
         r_unsigned <= bus.req_unsigned_i;
         r_err      <= w_err;
      end
   end

   assign bus.resp_err_o = (r_state == RESP) && r_err;
`else
   logic w_unused_bits;

   // Word-only build: size, signedness and the byte offset carry no meaning.
   assign w_unused_bits = ^{bus.req_addr_i, bus.req_size_i, bus.req_unsigned_i, r_addr[1:0]};
   assign w_next_acc    = bus.req_we_i ? WRITE : READ;
   assign w_load        = mem_bus_io;
   assign w_merge       = r_wword;
   assign bus.resp_err_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wword <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= w_next_acc;
                  r_we    <= bus.req_we_i;
                  r_addr  <= bus.req_addr_i[MEM_AW-1:0];
                  r_wword <= bus.req_wdata_i;
                  r_rdata <= '0;
               end
            end
            READ: begin
               r_state <= r_we ? WRITE : RESP;
               if (r_we)
                  r_wword <= w_merge;
               else
                  r_rdata <= w_load;
            end
            WRITE:   r_state <= RESP;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready_o  = (r_state == IDLE);
   assign bus.resp_valid_o = (r_state == RESP);
   assign bus.resp_rdata_o = r_rdata;
   assign bus.mem_addr_o   = {r_addr[MEM_AW-1:2], 2'b00};
   assign bus.mem_re_o     = (r_state == READ);
   assign bus.mem_we_o     = (r_state == WRITE);
   assign mem_bus_io       = (r_state == WRITE) ? r_wword : 32'bz;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-addressed memory model on the shared bus plus a per-cycle response checker.
module tb_load_store_unit;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if #(.MEM_AW(AW)) lsu();
   tri [31:0] mem_bus;

   load_store_unit #(.MEM_AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (lsu.slave),
      .mem_bus_io (mem_bus)
   );

   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];

   assign mem_bus = lsu.mem_re_o ? mem[lsu.mem_addr_o[7:2]] : 32'bz;
   always @(posedge clk) if (lsu.mem_we_o) mem[lsu.mem_addr_o[7:2]] = mem_bus;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit          run_checks = 1'b0;
   bit          exp_pending = 1'b0;
   int          exp_issue, exp_cycle, exp_nre, exp_nwe, exp_idx;
   logic [31:0] exp_rdata, exp_nword;
   logic        exp_err, exp_store;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;
   int          n_re = 0, n_we = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Reference behaviour computed straight from the access rules on a word array.
   task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err,
                        output int nre, output int nwe, output logic [31:0] nword);
      logic [31:0] w, v, mask;
      int off;
      w = ref_mem[addr[7:2]];
      off = int'(addr[1:0]);
      rd = 32'd0; err = 1'b0; nword = w; nre = 0; nwe = 0; lat = 2;
`ifdef LSU_SUBWORD_EN
      err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && off != 0);
`else
      sz = 2'd2;
`endif
      if (err) begin
         lat = 1;
      end else if (!we) begin
         nre = 1;
         if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
         end else if (sz == 2'd1) begin
            v = (w >> (8 * off)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
         end else begin
            v = w;
         end
         rd = v;
      end else begin
         nwe = 1;
         if (sz == 2'd2) begin
            nword = wd;
         end else begin
            lat = 3;
            nre = 1;
            mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
            nword = (w & ~mask) | ((wd << (8 * off)) & mask);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst && run_checks) begin
         if (!exp_pending) begin
            n_re = 0;
            n_we = 0;
            chk("resp_unexpected", 32'(lsu.resp_valid_o), 32'd0);
         end
         n_re += int'(lsu.mem_re_o);
         n_we += int'(lsu.mem_we_o);
         chk("re_we_overlap", 32'(lsu.mem_re_o && lsu.mem_we_o), 32'd0);
         chk("req_ready", 32'(lsu.req_ready_o),
             32'(!(exp_pending && cyc > exp_issue && cyc <= exp_cycle)));
         if (lsu.resp_valid_o && exp_pending) begin
            chk("resp_cycle", 32'(cyc - exp_issue), 32'(exp_cycle - exp_issue));
            chk("resp_rdata", lsu.resp_rdata_o, exp_rdata);
            chk("resp_err", 32'(lsu.resp_err_o), 32'(exp_err));
            chk("re_count", 32'(n_re), 32'(exp_nre));
            chk("we_count", 32'(n_we), 32'(exp_nwe));
            if (exp_store) ref_mem[exp_idx] = exp_nword;
            chk("mem_word", mem[exp_idx], ref_mem[exp_idx]);
            last_rdata  = lsu.resp_rdata_o;
            last_err    = lsu.resp_err_o;
            exp_pending = 1'b0;
         end else if (!lsu.resp_valid_o) begin
            chk("err_outside_resp", 32'(lsu.resp_err_o), 32'd0);
            if (exp_pending && cyc >= exp_cycle) begin
               chk("resp_missing", 32'(lsu.resp_valid_o), 32'd1);
               exp_pending = 1'b0;
            end
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 20 && exp_pending; i++) @(negedge clk);
      if (exp_pending) begin
         chk("idle_timeout", 32'(exp_pending), 32'd0);
         exp_pending = 1'b0;
      end
   endtask

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      int lat, nre, nwe;
      logic [31:0] rd, nword;
      logic err;
      wait_idle();
      @(negedge clk);
      model(we, sz, uns, addr, wd, lat, rd, err, nre, nwe, nword);
      exp_issue = cyc;  exp_cycle = cyc + lat;
      exp_rdata = rd;   exp_err = err;
      exp_nre = nre;    exp_nwe = nwe;
      exp_idx = int'(addr[7:2]);
      exp_nword = nword;
      exp_store = we && !err;
      exp_pending = 1'b1;
      lsu.req_valid_i = 1'b1;  lsu.req_we_i = we;  lsu.req_size_i = sz;
      lsu.req_unsigned_i = uns; lsu.req_addr_i = addr; lsu.req_wdata_i = wd;
      @(posedge clk);
      #1;
      lsu.req_valid_i = 1'b0;
   endtask

   task automatic expect_rd(input string name, input logic [31:0] rd, input logic err);
      wait_idle();
      chk(name, last_rdata, rd);
      chk({name, "_err"}, 32'(last_err), 32'(err));
   endtask

   task automatic expect_mem(input string name, input logic [31:0] addr, input logic [31:0] val);
      wait_idle();
      chk(name, mem[addr[7:2]], val);
   endtask

   task automatic preset(input logic [31:0] addr, input logic [31:0] val);
      mem[addr[7:2]] = val;
      ref_mem[addr[7:2]] = val;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(lsu.req_ready_o), 32'd1);
      chk({tag, "_resp_valid"}, 32'(lsu.resp_valid_o), 32'd0);
      chk({tag, "_resp_err"}, 32'(lsu.resp_err_o), 32'd0);
      chk({tag, "_resp_rdata"}, lsu.resp_rdata_o, 32'd0);
      chk({tag, "_mem_re"}, 32'(lsu.mem_re_o), 32'd0);
      chk({tag, "_mem_we"}, 32'(lsu.mem_we_o), 32'd0);
   endtask

   task automatic idle_reset(input string tag);
      wait_idle();
      rst = 1'b1;
      #1;
      check_reset_outputs(tag);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Abandons the access in flight once the wanted strobe is up; memory must be untouched.
   task automatic reset_mid(input string tag, input bit on_write);
      logic [31:0] saved;
      for (int i = 0; i < 8; i++) begin
         if (on_write ? lsu.mem_we_o : lsu.mem_re_o) break;
         @(negedge clk);
      end
      chk({tag, "_strobe_seen"}, 32'(on_write ? lsu.mem_we_o : lsu.mem_re_o), 32'd1);
      saved = mem[exp_idx];
      rst = 1'b1;
      #1;
      exp_pending = 1'b0;
      check_reset_outputs(tag);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk({tag, "_mem_kept"}, mem[exp_idx], saved);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      lsu.req_valid_i = 1'b0; lsu.req_we_i = 1'b0; lsu.req_size_i = 2'b10;
      lsu.req_unsigned_i = 1'b0; lsu.req_addr_i = '0; lsu.req_wdata_i = '0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'h1000_0000 + 32'(i);
         ref_mem[i] = 32'h1000_0000 + 32'(i);
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      rst = 1'b0;
      run_checks = 1'b1;

      preset(32'h10, 32'hDEADBEEF);
      preset(32'h30, 32'h01020304);
      preset(32'h50, 32'h5A5A5A5A);
      preset(32'h04, 32'h89ABCDEF);

      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      expect_rd("ld_word_0x10", 32'hDEADBEEF, 1'b0);
      idle_reset("idle_rst");

      issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D);
      expect_mem("st_word_0x30", 32'h30, 32'hCAFEF00D);
      expect_rd("st_word_rdata", 32'h0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      expect_rd("ld_back_0x30", 32'hCAFEF00D, 1'b0);

      issue(1'b1, 2'b10, 1'b0, 32'h50, 32'h11111111);
      reset_mid("rst_wr", 1'b1);
      expect_mem("rst_wr_word", 32'h50, 32'h5A5A5A5A);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      reset_mid("rst_rd", 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      expect_rd("ld_after_rst", 32'hDEADBEEF, 1'b0);

      for (int i = 0; i < 4; i++)
         issue(1'b1, 2'b10, 1'b0, 32'h80 + 32'(4 * i), 32'hA5000000 ^ (32'h01234567 << i));
      for (int i = 0; i < 4; i++)
         issue(1'b0, 2'b10, 1'b0, 32'h80 + 32'(4 * i), 32'h0);

`ifdef LSU_SUBWORD_EN
      preset(32'h10, 32'h80FF1234);
      issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      expect_rd("ld_sbyte_0x13", 32'hFFFFFF80, 1'b0);
      issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
      expect_rd("ld_ubyte_0x13", 32'h00000080, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
      expect_rd("ld_shalf_0x12", 32'hFFFF80FF, 1'b0);
      issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
      expect_rd("ld_uhalf_0x10", 32'h00001234, 1'b0);
      issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
      expect_rd("ld_sbyte_0x11", 32'h00000012, 1'b0);

      preset(32'h20, 32'h11223344);
      issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD);
      expect_mem("st_half_0x22", 32'h20, 32'hABCD3344);
      preset(32'h24, 32'hAABBCCDD);
      issue(1'b1, 2'b00, 1'b0, 32'h25, 32'hFFFFFF77);
      expect_mem("st_byte_0x25", 32'h24, 32'hAABB77DD);
      issue(1'b1, 2'b01, 1'b0, 32'h24, 32'h00008001);
      expect_mem("st_half_0x24", 32'h24, 32'hAABB8001);

      issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
      expect_rd("err_ld_word_0x06", 32'h0, 1'b1);
      issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
      expect_rd("err_ld_half_0x21", 32'h0, 1'b1);
      issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
      expect_rd("err_size_11", 32'h0, 1'b1);
      issue(1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678);
      expect_mem("err_st_kept", 32'h20, 32'hABCD3344);

      preset(32'h60, 32'h12345678);
      issue(1'b1, 2'b00, 1'b0, 32'h61, 32'h00000099);
      reset_mid("rst_rmw", 1'b1);
      expect_mem("rst_rmw_word", 32'h60, 32'h12345678);
`else
      preset(32'h40, 32'hFFFFFFFF);
      issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h00000055);
      expect_mem("st_byte_as_word", 32'h40, 32'h00000055);
      expect_rd("st_byte_as_word_rd", 32'h0, 1'b0);
      issue(1'b0, 2'b00, 1'b0, 32'h43, 32'h0);
      expect_rd("ld_byte_as_word", 32'h00000055, 1'b0);
      issue(1'b0, 2'b11, 1'b0, 32'h06, 32'h0);
      expect_rd("ld_size11_word", 32'h89ABCDEF, 1'b0);
`endif

      wait_idle();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
